bayes_seq_ctrl: RTL
===================

Name: bayes_seq_ctrl

Overview:
- AXI4-Lite master that runs one complete MNIST classification on the Bayes accelerator register slave, so the CPU no longer drives each register access itself.
- Takes a pixel-word stream, writes each word to the accelerator DATA register, then writes START to CTRL.
- Polls STATUS until DONE is set, reads RESULT, and returns the class on a valid/ready result port.
- Sits between the pixel source (DMA/FIFO) and the Bayes slave's AXI-Lite port.

Parameters:
- C_AXI_DATA_WIDTH, 32, M_AXI data width; only 32 is supported.
- C_AXI_ADDR_WIDTH, 6, M_AXI address width.
- REG_CTRL, 6'h00, CTRL register address; bit0 = START.
- REG_STAT, 6'h04, STATUS register address; bit0 = DONE.
- REG_DATA, 6'h08, DATA register address (pixel word write).
- REG_RES, 6'h0C, RESULT register address; bits[3:0] = class.
- POLL_GAP, 4, idle cycles between STATUS reads.
- POLL_MAX, 1024, maximum STATUS reads before timeout error.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- pix_valid  in  1  pixel word valid.
- pix_ready  out  1  pixel word accepted.
- pix_data  in  32  pixel word.
- pix_last  in  1  last word of the image.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_class  out  4  predicted digit.
- res_err  out  1  error: bad response or timeout.
- busy  out  1  high whenever state != FETCH.
- M_AXI_AWADDR  out  C_AXI_ADDR_WIDTH  write address.
- M_AXI_AWPROT  out  3  tied to 3'b000.
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_WDATA  out  32  write data.
- M_AXI_WSTRB  out  4  tied to 4'hF.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- M_AXI_ARADDR  out  C_AXI_ADDR_WIDTH  read address.
- M_AXI_ARPROT  out  3  tied to 3'b000.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  32  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.

Behaviour:
- Reset (async, ARESETN low): state=FETCH; all *VALID, BREADY, RREADY, res_valid, res_err = 0; res_class=0; err flag, poll counter, gap counter = 0.
- pix_ready is high only in FETCH and DRAIN.
- A reset mid-transaction abandons the transaction; the slave must be reset together with this block.
- States:
  - FETCH: on pix_valid, latch pix_data and pix_last -> WR, with AWADDR=REG_DATA, WDATA=word.
  - WR: AWVALID and WVALID rise together in the first WR cycle. Each drops independently on its own handshake and is never re-raised within the transaction. AW/W handshakes may occur in either order or in the same cycle. Go to WB when both have completed.
  - WB: BREADY=1. On BVALID:
    - BRESP!=OKAY: set err -> DRAIN if the latched word was not last, else OUT.
    - Else, after a DATA write: not last -> FETCH; last -> WR, with AWADDR=REG_CTRL, WDATA=1.
    - Else, after a CTRL write -> RD, with ARADDR=REG_STAT.
  - RD: ARVALID=1 until ARREADY -> RW.
  - RW: RREADY=1. On RVALID:
    - RRESP!=OKAY: set err -> OUT.
    - STATUS read with DONE=1 -> RD, with ARADDR=REG_RES.
    - STATUS read with DONE=0: increment the poll counter; if it reaches POLL_MAX, set err -> OUT; else -> GAP.
    - RESULT read: res_class=RDATA[3:0] -> OUT.
  - GAP: wait POLL_GAP cycles -> RD (STATUS).
  - DRAIN: accept and discard pixel words until one with pix_last=1 is accepted -> OUT.
  - OUT: res_valid=1 and res_err=err. res_class=0 when err. Outputs are held stable until res_ready. On the res_ready handshake: clear err, poll counter and res_valid -> FETCH.
- Latency, zero-wait slave:
  - 3 cycles per pixel word: FETCH, WR, WB.
  - Each STATUS poll: 2 cycles, plus POLL_GAP cycles when DONE=0.
- A single-word image (first word has pix_last=1) is legal.
- Only one AXI transaction is outstanding at any time; the read and write channels are never active together.

Test Plan:
- 4-word image, zero-wait slave, DONE on the first poll, RESULT=7 -> four DATA writes, then CTRL write of 1, then one STATUS read and one RESULT read; res_class=7, res_err=0. Also check: res held while res_ready=0 for 5 cycles; 3-cycle per-word spacing.
- Slave accepts AW 3 cycles before W, then W before AW, then both in the same cycle -> exactly one write per word, with no duplicate AWVALID or WVALID.
- DONE set on the 3rd poll, POLL_GAP=4 -> exactly 3 STATUS reads, with gap cycles between them; correct class output.
- SLVERR on the 2nd DATA write of a 5-word image -> remaining 3 words drained, no further AXI traffic; res_err=1, res_class=0; next image then completes normally.
- DONE never set, POLL_MAX=8 -> 8 STATUS reads, then res_err=1.
- Reset asserted during the poll phase -> all outputs reach reset values asynchronously; after release, pix_ready=1 and busy=0.

Source files
------------

// File: rtl/bayes_seq_ctrl.sv
// AXI4-Lite master that pushes one image into the Bayes accelerator, starts it,
// polls STATUS until DONE and returns the predicted class on a valid/ready port.
module bayes_seq_ctrl #(
    parameter int                          C_AXI_DATA_WIDTH = 32,
    parameter int                          C_AXI_ADDR_WIDTH = 6,
    parameter logic [C_AXI_ADDR_WIDTH-1:0] REG_CTRL         = 'h00,
    parameter logic [C_AXI_ADDR_WIDTH-1:0] REG_STAT         = 'h04,
    parameter logic [C_AXI_ADDR_WIDTH-1:0] REG_DATA         = 'h08,
    parameter logic [C_AXI_ADDR_WIDTH-1:0] REG_RES          = 'h0C,
    parameter int                          POLL_GAP         = 4,
    parameter int                          POLL_MAX         = 1024
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,

    input  logic                            pix_valid,
    output logic                            pix_ready,
    input  logic [C_AXI_DATA_WIDTH-1:0]     pix_data,
    input  logic                            pix_last,

    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [3:0]                      res_class,
    output logic                            res_err,
    output logic                            busy,

    output logic [C_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int         PW   = $clog2(POLL_MAX + 1);
    localparam int         GW   = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [1:0] OKAY = 2'b00;

    typedef enum logic [2:0] {FETCH, WR, WB, RD, RW, GAP, DRAIN, OUT} state_t;

    state_t        state;
    logic          err;
    logic          last_word;
    logic          ctrl_phase;
    logic          res_phase;
    logic [PW-1:0] poll_cnt;
    logic [GW-1:0] gap_cnt;
    logic          unused_rdata;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;
    assign pix_ready    = (state == FETCH) || (state == DRAIN);
    assign busy         = (state != FETCH);
    assign unused_rdata = ^M_AXI_RDATA[C_AXI_DATA_WIDTH-1:4];

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state         <= FETCH;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            res_valid     <= 1'b0;
            res_class     <= '0;
            res_err       <= 1'b0;
            err           <= 1'b0;
            last_word     <= 1'b0;
            ctrl_phase    <= 1'b0;
            res_phase     <= 1'b0;
            poll_cnt      <= '0;
            gap_cnt       <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (pix_valid) begin
                        last_word     <= pix_last;
                        ctrl_phase    <= 1'b0;
                        M_AXI_AWADDR  <= REG_DATA;
                        M_AXI_WDATA   <= pix_data;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        state         <= WR;
                    end
                end

                // Address and data channels retire independently, in any order.
                WR: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WB;
                    end
                end

                WB: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        if (M_AXI_BRESP != OKAY) begin
                            err <= 1'b1;
                            if (last_word) begin
                                res_valid <= 1'b1;
                                res_err   <= 1'b1;
                                res_class <= '0;
                                state     <= OUT;
                            end else begin
                                state <= DRAIN;
                            end
                        end else if (ctrl_phase) begin
                            M_AXI_ARADDR  <= REG_STAT;
                            M_AXI_ARVALID <= 1'b1;
                            res_phase     <= 1'b0;
                            state         <= RD;
                        end else if (last_word) begin
                            M_AXI_AWADDR  <= REG_CTRL;
                            M_AXI_WDATA   <= C_AXI_DATA_WIDTH'(1);
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            ctrl_phase    <= 1'b1;
                            state         <= WR;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end

                RD: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RW;
                    end
                end

                // res_phase tells a RESULT read apart from a STATUS poll.
                RW: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        if (M_AXI_RRESP != OKAY) begin
                            err       <= 1'b1;
                            res_valid <= 1'b1;
                            res_err   <= 1'b1;
                            res_class <= '0;
                            state     <= OUT;
                        end else if (res_phase) begin
                            res_valid <= 1'b1;
                            res_err   <= err;
                            res_class <= M_AXI_RDATA[3:0];
                            state     <= OUT;
                        end else if (M_AXI_RDATA[0]) begin
                            M_AXI_ARADDR  <= REG_RES;
                            M_AXI_ARVALID <= 1'b1;
                            res_phase     <= 1'b1;
                            state         <= RD;
                        end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
                            poll_cnt  <= poll_cnt + 1'b1;
                            err       <= 1'b1;
                            res_valid <= 1'b1;
                            res_err   <= 1'b1;
                            res_class <= '0;
                            state     <= OUT;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                            gap_cnt  <= '0;
                            state    <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == GW'(POLL_GAP - 1)) begin
                        M_AXI_ARADDR  <= REG_STAT;
                        M_AXI_ARVALID <= 1'b1;
                        state         <= RD;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                DRAIN: begin
                    if (pix_valid && pix_last) begin
                        res_valid <= 1'b1;
                        res_err   <= err;
                        res_class <= '0;
                        state     <= OUT;
                    end
                end

                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                        err       <= 1'b0;
                        poll_cnt  <= '0;
                        state     <= FETCH;
                    end
                end

                default: state <= FETCH;
            endcase
        end
    end

endmodule
